avalon_multi_timer: RTL and testbench
=====================================

Name: avalon_multi_timer

Overview:
Parametrised Avalon-MM interval timer for the Nios II system. It holds NUM_CH independent down-counting channels behind one slave port. Each channel has a CNT_W-bit period, an 8-bit clock prescaler, one-shot or continuous mode, counter snapshot, and a compare-based PWM output. Per-channel interrupts are provided, plus an OR-combined irq for the CPU interrupt controller.

Parameters:
NUM_CH, 2, number of timer channels (1..8, power of two)
CNT_W, 32, counter/period/compare width (8..32)
RESET_PERIOD, 49999, reset value of every period register and counter
ADDR_W, $clog2(NUM_CH)+3, address width (derived localparam, not overridden)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_W  word address; [ADDR_W-1:3]=channel, [2:0]=register offset
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
read_n  in  1  active-low read strobe (readdata updates regardless; fixed latency 1)
writedata  in  32  write data
readdata  out  32  registered read data
irq_vec  out  NUM_CH  per-channel interrupt
irq  out  1  OR of irq_vec
pwm_out  out  NUM_CH  per-channel PWM output, registered

Behaviour:
- Reset: reset_n is an asynchronous, active-low reset; clock is clk. All state clears on reset_n low, including mid-count.
- Reset values:
  - counter and period = RESET_PERIOD
  - compare, snapshot, control, prescale counter, status = 0
  - readdata = 0, irq_vec = 0, irq = 0, pwm_out = 0
- Register map (per channel, offset):
  - 0 STATUS: bit0 TO (timeout), bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO (irq enable), bit1 CONT, bit2 START (self-clearing, reads 0), bit3 STOP (self-clearing, reads 0), bit4 PWM_EN, bits[15:8] PRESC.
  - 2 PERIOD
  - 3 COMPARE
  - 4 SNAPSHOT: a write captures the live counter; a read returns the captured value.
  - 5..7 reserved: read 0, writes ignored.
- Width rules: writes use writedata[CNT_W-1:0]; reads zero-extend to 32 bits.
- Read path: readdata is registered from the address mux every cycle, so read latency is 1 clock.
- Prescaler:
  - pre_cnt counts down from PRESC to 0. tick = running && pre_cnt==0; on tick, pre_cnt reloads PRESC.
  - PRESC=0 gives a tick every clock while running.
  - pre_cnt reloads PRESC on START and on a PERIOD write.
- Counter:
  - On tick: if counter==0, load PERIOD, set TO, and clear RUN if CONT=0. Otherwise decrement by 1.
  - Timeout interval = (PERIOD+1)*(PRESC+1) clocks.
  - PERIOD=0 with CONT=1 gives a timeout every tick.
- START/STOP:
  - START sets RUN the cycle after the write. Counting resumes from the current counter value; no reload.
  - STOP clears RUN; the counter holds.
  - START and STOP written together: STOP wins.
  - START while already running: no effect on counter or prescaler.
- PERIOD write:
  - Next cycle: counter := new PERIOD, pre_cnt := PRESC, RUN := 0 (force-reload, stop).
  - Software must issue START to resume.
- TO clear race: a STATUS write on the same cycle as a timeout leaves TO=1 (set wins).
- Interrupts:
  - irq_vec[i] = TO[i] & ITO[i] (combinational from registers).
  - irq = |irq_vec.
- PWM:
  - pwm_out[i] registered: PWM_EN & RUN & (counter < COMPARE).
  - COMPARE=0 gives a constant 0; COMPARE > PERIOD gives a constant 1 while running.
- Snapshot: the snapshot register captures the counter value present on the write cycle, not the post-write value.
- Chip select: writes without chipselect are ignored. Accesses to a channel index >= NUM_CH read 0 and write nothing.

Test Plan:
- Reset check: after reset, read ch0 PERIOD -> 49999 (after 1-cycle latency); STATUS -> 0; irq=0; pwm_out=0.
- One-shot with irq: ch1 PERIOD=9, CONTROL=0x05 (ITO|START).
  - TO sets exactly 10 ticks after RUN rises; RUN then clears.
  - irq_vec=2'b10 and irq=1.
  - STATUS write -> irq drops next cycle.
- Continuous with prescaler: ch0 PERIOD=3, CONTROL=0x0306 (PRESC=3, CONT|START) -> timeouts every 16 clocks across 3 periods. Snapshot written mid-count returns a value in 0..3.
- PWM: ch0 PERIOD=9, COMPARE=3, CONTROL=0x16 -> pwm_out[0] high 3 of every 10 ticks. COMPARE=0 -> constant low; COMPARE=20 -> constant high.
- Collisions:
  - START|STOP written together -> RUN stays 0.
  - STATUS write on the timeout cycle -> TO remains 1.
  - PERIOD write while running -> counter=new value, RUN=0 next cycle.
- Async reset mid-count: assert reset_n low asynchronously between clock edges -> all outputs 0 immediately; counter=49999 after release.

Source files
------------

// File: rtl/avalon_multi_timer.sv
// Multi-channel Avalon-MM interval timer: per-channel down-counter with prescaler,
// one-shot/continuous mode, snapshot, compare-based PWM and timeout interrupts.
module avalon_multi_timer #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999,
  localparam int ADDR_W      = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0]  counter  [NUM_CH];
  logic [CNT_W-1:0]  period   [NUM_CH];
  logic [CNT_W-1:0]  compare  [NUM_CH];
  logic [CNT_W-1:0]  snapshot [NUM_CH];
  logic [7:0]        presc    [NUM_CH];
  logic [7:0]        pre_cnt  [NUM_CH];
  logic [NUM_CH-1:0] ito, cont, pwm_en, to, run, tick, sel;

  logic [CH_W-1:0]  ch;
  logic [2:0]       off;
  logic             wr;
  logic [CNT_W-1:0] wr_val;
  logic [31:0]      rd_mux;
  logic             unused_read_n;

  // NUM_CH is a power of two, so every channel index the address can carry exists.
  generate
    if (NUM_CH > 1) begin : g_multi
      assign ch = address[ADDR_W-1:3];
    end else begin : g_single
      assign ch = 1'b0;
    end
  endgenerate

  assign off           = address[2:0];
  assign wr            = chipselect & ~write_n;
  assign wr_val        = writedata[CNT_W-1:0];
  assign unused_read_n = read_n;

  always_comb begin
    sel  = '0;
    tick = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel[i]  = wr && (ch == CH_W'(i));
      tick[i] = run[i] && (pre_cnt[i] == 8'd0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        counter[i]  <= RST_P;
        period[i]   <= RST_P;
        compare[i]  <= '0;
        snapshot[i] <= '0;
        presc[i]    <= '0;
        pre_cnt[i]  <= '0;
      end
      ito     <= '0;
      cont    <= '0;
      pwm_en  <= '0;
      to      <= '0;
      run     <= '0;
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= pwm_en[i] & run[i] & (counter[i] < compare[i]);

        if (tick[i]) begin
          pre_cnt[i] <= presc[i];
          if (counter[i] == '0) begin
            counter[i] <= period[i];
            if (!cont[i]) run[i] <= 1'b0;
          end else begin
            counter[i] <= counter[i] - ONE;
          end
        end else if (run[i]) begin
          pre_cnt[i] <= pre_cnt[i] - 8'd1;
        end

        // A timeout on the same cycle as a STATUS write keeps TO set.
        if (tick[i] && (counter[i] == '0)) to[i] <= 1'b1;
        else if (sel[i] && (off == 3'd0)) to[i] <= 1'b0;

        if (sel[i]) begin
          case (off)
            3'd1: begin
              ito[i]    <= writedata[0];
              cont[i]   <= writedata[1];
              pwm_en[i] <= writedata[4];
              presc[i]  <= writedata[15:8];
              if (writedata[3]) begin
                run[i] <= 1'b0;
              end else if (writedata[2] && !run[i]) begin
                run[i]     <= 1'b1;
                pre_cnt[i] <= writedata[15:8];
              end
            end
            3'd2: begin
              period[i]  <= wr_val;
              counter[i] <= wr_val;
              pre_cnt[i] <= presc[i];
              run[i]     <= 1'b0;
            end
            3'd3: compare[i]  <= wr_val;
            3'd4: snapshot[i] <= counter[i];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      3'd0: rd_mux = {30'b0, run[ch], to[ch]};
      3'd1: rd_mux = {16'b0, presc[ch], 3'b0, pwm_en[ch], 2'b0, cont[ch], ito[ch]};
      3'd2: rd_mux = 32'(period[ch]);
      3'd3: rd_mux = 32'(compare[ch]);
      3'd4: rd_mux = 32'(snapshot[ch]);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq_vec = to & ito;
  assign irq     = |irq_vec;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed bench for avalon_multi_timer: register table plus timing/corner sequences.
module tb_avalon_multi_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  irq_vec;
  logic        irq;
  logic [1:0]  pwm_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic        cs;
    logic [3:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  avalon_multi_timer dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .irq_vec(irq_vec), .irq(irq), .pwm_out(pwm_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_op(input logic cs, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = cs; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_op(1'b1, a, d);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    d = readdata; chipselect = 1'b0; read_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int k_hit, n_to, cnt;
    int to_at[3];

    address = '0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; writedata = '0;

    vecs[0]  = '{1'b0, 1'b1, 4'h2, 32'd49999};
    vecs[1]  = '{1'b0, 1'b1, 4'h0, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 4'hA, 32'd49999};
    vecs[3]  = '{1'b0, 1'b1, 4'h1, 32'h0};
    vecs[4]  = '{1'b0, 1'b1, 4'h3, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 4'h4, 32'h0};
    vecs[6]  = '{1'b1, 1'b1, 4'hB, 32'h1234_5678};
    vecs[7]  = '{1'b0, 1'b1, 4'hB, 32'h1234_5678};
    vecs[8]  = '{1'b1, 1'b1, 4'h1, 32'h0000_AB13};
    vecs[9]  = '{1'b0, 1'b1, 4'h1, 32'h0000_AB13};
    vecs[10] = '{1'b1, 1'b1, 4'h1, 32'h0000_000C};
    vecs[11] = '{1'b0, 1'b1, 4'h1, 32'h0};
    vecs[12] = '{1'b1, 1'b1, 4'h5, 32'hFFFF_FFFF};
    vecs[13] = '{1'b0, 1'b1, 4'h5, 32'h0};
    vecs[14] = '{1'b0, 1'b1, 4'h7, 32'h0};
    vecs[15] = '{1'b1, 1'b0, 4'h3, 32'h0000_DEAD};
    vecs[16] = '{1'b0, 1'b1, 4'h3, 32'h0};
    vecs[17] = '{1'b0, 1'b1, 4'h0, 32'h0};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_irq_vec", {30'b0, irq_vec}, 32'h0);
    check("rst_pwm", {30'b0, pwm_out}, 32'h0);
    check("rst_readdata", readdata, 32'h0);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) begin
        bus_op(vecs[i].cs, vecs[i].addr, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_addr%0h", i, vecs[i].addr), rd, vecs[i].data);
      end
    end

    // One-shot on ch1: TO ten ticks after RUN rises, then RUN drops.
    bus_write(4'hA, 32'd9);
    bus_write(4'h9, 32'h05);
    k_hit = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (irq && k_hit == 0) k_hit = k;
    end
    check("oneshot_latency", k_hit, 10);
    bus_read(4'h8, rd);
    check("oneshot_status", rd, 32'h1);
    check("oneshot_irq_vec", {30'b0, irq_vec}, 32'h2);
    check("oneshot_irq", {31'b0, irq}, 32'h1);
    bus_write(4'h8, 32'h0);
    check("status_clear_irq", {31'b0, irq}, 32'h0);

    // Continuous ch0 with PRESC=3: timeouts every 16 clocks, cleared by software.
    bus_write(4'h2, 32'd3);
    bus_write(4'h1, 32'h0307);
    n_to = 0;
    to_at = '{0, 0, 0};
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      if (irq) begin
        if (n_to < 3) to_at[n_to] = k;
        n_to++;
        address = 4'h0; writedata = '0; chipselect = 1'b1; write_n = 1'b0;
      end
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    check("cont_count", n_to, 3);
    check("cont_to0", to_at[0], 16);
    check("cont_to1", to_at[1], 32);
    check("cont_to2", to_at[2], 48);
    bus_write(4'h4, 32'h0);
    bus_read(4'h4, rd);
    check("snap_range", {31'b0, (rd <= 32'd3)}, 32'h1);
    bus_write(4'h1, 32'h08);
    bus_write(4'h0, 32'h0);

    // PWM on ch0: 3 of every 10 ticks, then constant low / constant high.
    bus_write(4'h2, 32'd9);
    bus_write(4'h3, 32'd3);
    bus_write(4'h1, 32'h16);
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      cnt += int'(pwm_out[0]);
    end
    check("pwm_duty_3of10", cnt, 9);
    check("pwm_ch1_idle", {31'b0, pwm_out[1]}, 32'h0);
    bus_write(4'h3, 32'd0);
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cnt += int'(pwm_out[0]);
    end
    check("pwm_cmp0_low", cnt, 0);
    bus_write(4'h3, 32'd20);
    @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      cnt += int'(pwm_out[0]);
    end
    check("pwm_cmp20_high", cnt, 20);
    bus_write(4'h1, 32'h08);
    bus_write(4'h0, 32'h0);

    // START and STOP together: STOP wins.
    bus_write(4'h1, 32'h0C);
    bus_read(4'h0, rd);
    check("start_stop_run", rd, 32'h0);

    // PERIOD write while running: force reload and stop.
    bus_write(4'h2, 32'd100);
    bus_write(4'h1, 32'h06);
    repeat (5) @(negedge clk);
    bus_read(4'h0, rd);
    check("running_before_period", rd, 32'h2);
    bus_write(4'h2, 32'd50);
    bus_read(4'h0, rd);
    check("period_write_stops", rd, 32'h0);
    bus_write(4'h4, 32'h0);
    bus_read(4'h4, rd);
    check("period_write_reload", rd, 32'd50);

    // STATUS write landing on the timeout cycle of ch1 leaves TO set.
    bus_write(4'hA, 32'd4);
    bus_write(4'h9, 32'h05);
    repeat (4) @(negedge clk);
    address = 4'h8; writedata = '0; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    check("to_race_irq_vec", {30'b0, irq_vec}, 32'h2);

    // Async reset mid-count with irq, pwm and readdata all non-zero.
    bus_write(4'h2, 32'd100);
    bus_write(4'h3, 32'd200);
    bus_write(4'h1, 32'h16);
    address = 4'h2;
    repeat (3) @(negedge clk);
    check("pre_reset_pwm", {30'b0, pwm_out}, 32'h1);
    check("pre_reset_irq", {31'b0, irq}, 32'h1);
    check("pre_reset_readdata", readdata, 32'd100);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_readdata", readdata, 32'h0);
    check("async_rst_pwm", {30'b0, pwm_out}, 32'h0);
    check("async_rst_irq_vec", {30'b0, irq_vec}, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_write(4'h4, 32'h0);
    bus_read(4'h4, rd);
    check("post_reset_counter", rd, 32'd49999);
    bus_read(4'h0, rd);
    check("post_reset_status", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
